match_report_queue: RTL and testbench
=====================================

# match_report_queue

Downstream collector for the rule outputs of the NFA engine. It samples the per-rule match vector each character cycle and stamps each match with the byte offset. It serialises simultaneous matches lowest-rule-first into a first-word-fall-through report FIFO drained through a valid/ready handshake. It back-pressures the character feeder through `hold` while it is serialising or while the FIFO is full.

## Interface
Parameters:
- `NUM_RULES`, 32: width of the match vector; one bit per rule block output.
- `RULE_W`, 5: rule index width; ceil(log2(NUM_RULES)).
- `OFFSET_W`, 32: byte-offset counter width.
- `DEPTH`, 16: FIFO entries; power of two.
- `ADDR_W`, 4: log2(DEPTH).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: character-accept strobe; same signal that enables the engine.
- `match` in NUM_RULES: rule outputs; sampled only when `en`=1.
- `hold` out 1: feeder must not assert `en` while this is high.
- `rpt_valid` out 1: head FIFO entry is valid.
- `rpt_ready` in 1: consumer accepts the head entry.
- `rpt_rule` out RULE_W: rule index of the head entry.
- `rpt_offset` out OFFSET_W: byte offset of the head entry.
- `count` out ADDR_W+1: FIFO occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a nonzero match vector was dropped.

## Operation
- Offset counter `ofs`: resets to 0 and increments by 1 on every `en`=1 cycle, including dropped or blocked ones. It wraps modulo 2^OFFSET_W with no flag.
- FSM has two states, IDLE and DRAIN.
  - IDLE, `en`=1, `hold`=0, masked vector nonzero: load capture register `cap` with the vector, latch `cap_ofs`=`ofs`, go to DRAIN.
  - IDLE with a zero vector: no action.
- In DRAIN, a push is allowed when `count`<DEPTH, or when a pop happens in the same cycle.
  - On each allowed push, write {index of lowest set bit of `cap`, `cap_ofs`} and clear that bit.
  - The push that clears the last bit returns the FSM to IDLE.
  - A blocked push leaves `cap` unchanged.
- `hold` = (state==DRAIN) OR (`count`==DEPTH). It is combinational from registered state.
- Drop: `en`=1 while `hold`=1 with a nonzero vector discards the vector and sets `overflow`. Only `rst` clears `overflow`. A zero vector under `hold` is not an overflow.
- FIFO pop occurs when `rpt_valid` AND `rpt_ready`. Outputs present the head entry combinationally from RAM and the read pointer.
- Simultaneous push and pop when full: both occur and `count` is unchanged. Push and pop when empty: not possible, because a push lands one cycle before it is visible.
- Pointers are ADDR_W wide and wrap naturally. `count` is tracked separately.

## Timing
- Reset values: `hold`=0, `rpt_valid`=0, `count`=0, `overflow`=0, FSM in IDLE, `ofs`=0, `cap`=0. `rpt_rule` and `rpt_offset` are don't-care while `rpt_valid`=0.
- Latency: a vector captured at edge N pushes its first entry at edge N+1, so `rpt_valid` is high after edge N+1. A vector with k set bits and no FIFO stall leaves DRAIN after edge N+k, so `hold` is high for k cycles.
- Throughput: one report per cycle.
- `rst` asserted mid-DRAIN discards `cap` and FIFO contents on that edge.

## Configuration
- `MATCH_REPORT_DEDUP_EN` defined:
  - Register `prev` holds the last vector sampled with `en`=1.
  - The masked vector is `match & ~prev`, so a rule asserted on consecutive `en` cycles reports only its rising occurrence.
  - `prev` updates on every `en` cycle, including dropped ones, and resets to 0.
- `MATCH_REPORT_DEDUP_EN` undefined: the masked vector is `match`, and every asserted cycle reports.

## Test plan
- Single match: reset, `en`=1 for 5 cycles, `match`=32'h4 on the 4th cycle only, `rpt_ready`=1 → one report with rule=2, offset=3; `hold` high for 1 cycle; `overflow`=0.
- Multi-bit serialise: `match`=32'h8000_0011 at offset 0, `rpt_ready`=0 → entries (0,0), (4,0), (31,0); `hold` high for 3 cycles; `count`=3.
- Full/back-pressure: `rpt_ready`=0, 16 single-bit matches fill the FIFO → `count`=16 and `hold`=1. Another nonzero `en` → `overflow`=1 and `ofs` still increments. One pop → `hold` drops.
- Full with simultaneous push and pop: FIFO full, DRAIN pending, `rpt_ready`=1 → one push and one pop per cycle with `count` steady at 16; order is preserved.
- Reset mid-DRAIN: `match`=32'hF, `rst` on the 2nd DRAIN cycle → next cycle `count`=0, `hold`=0, `rpt_valid`=0.
- Dedup: `match`=32'h1 for 3 consecutive `en` cycles → 1 report with the macro defined, 3 reports without it. Offset wrap with OFFSET_W=4: the 17th `en` cycle reports offset 0.

Source files
------------

// File: rtl/match_report_queue.sv
// Match report collector: serialises per-rule matches lowest-first into a FWFT report FIFO.
// Optional rising-edge filtering of the match vector via MATCH_REPORT_DEDUP_EN.
module match_report_queue #(
    parameter int unsigned NUM_RULES = 32,
    parameter int unsigned RULE_W    = 5,
    parameter int unsigned OFFSET_W  = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_RULES-1:0] match,
    output logic                 hold,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic [RULE_W-1:0]    rpt_rule,
    output logic [OFFSET_W-1:0]  rpt_offset,
    output logic [ADDR_W:0]      count,
    output logic                 overflow
);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    localparam logic [ADDR_W:0] FullCount = (ADDR_W+1)'(DEPTH);

    state_e                       state;
    logic [NUM_RULES-1:0]         cap;
    logic [NUM_RULES-1:0]         cap_next;
    logic [OFFSET_W-1:0]          cap_ofs;
    logic [OFFSET_W-1:0]          ofs;
    logic [ADDR_W-1:0]            wptr;
    logic [ADDR_W-1:0]            rptr;
    logic [RULE_W+OFFSET_W-1:0]   ram [DEPTH];
    logic [NUM_RULES-1:0]         masked;
    logic [RULE_W-1:0]            low_idx;
    logic                         full;
    logic                         push;
    logic                         pop;

`ifdef MATCH_REPORT_DEDUP_EN
    logic [NUM_RULES-1:0] prev;

    // Tracks every accepted character, even dropped ones, so only rising matches report.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else if (en) begin
            prev <= match;
        end
    end

    assign masked = match & ~prev;
`else
    assign masked = match;
`endif

    assign full      = (count == FullCount);
    assign hold      = (state == StDrain) || full;
    assign rpt_valid = (count != '0);
    assign pop       = rpt_valid && rpt_ready;
    assign push      = (state == StDrain) && (!full || pop);
    assign cap_next  = cap & (cap - NUM_RULES'(1));

    always_comb begin
        low_idx = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (cap[i]) begin
                low_idx = RULE_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ram[wptr] <= {low_idx, cap_ofs};
        end
    end

    assign {rpt_rule, rpt_offset} = ram[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            cap      <= '0;
            cap_ofs  <= '0;
            ofs      <= '0;
            overflow <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            if (en) begin
                ofs <= ofs + OFFSET_W'(1);
            end
            if (en && hold && (masked != '0)) begin
                overflow <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (en && !hold && (masked != '0)) begin
                        cap     <= masked;
                        cap_ofs <= ofs;
                        state   <= StDrain;
                    end
                end
                StDrain: begin
                    if (push) begin
                        cap <= cap_next;
                        if (cap_next == '0) begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase

            if (push) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + ADDR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (ADDR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_match_report_queue.sv
// Scoreboard bench for match_report_queue; a second instance with a 4-bit offset covers wrap.
module tb_match_report_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] match;
    logic        hold;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [4:0]  rpt_rule;
    logic [31:0] rpt_offset;
    logic [4:0]  count;
    logic        overflow;

    logic        en2;
    logic [31:0] match2;
    logic        hold2;
    logic        rpt_valid2;
    logic [4:0]  rpt_rule2;
    logic [3:0]  rpt_offset2;
    logic [4:0]  count2;
    logic        overflow2;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] ofs_model;
    logic [36:0] sb[$];
    logic [36:0] exp_e;

    always #5 clk = ~clk;

    match_report_queue dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .match      (match),
        .hold       (hold),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_rule   (rpt_rule),
        .rpt_offset (rpt_offset),
        .count      (count),
        .overflow   (overflow)
    );

    match_report_queue #(.OFFSET_W(4)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .en         (en2),
        .match      (match2),
        .hold       (hold2),
        .rpt_valid  (rpt_valid2),
        .rpt_ready  (1'b1),
        .rpt_rule   (rpt_rule2),
        .rpt_offset (rpt_offset2),
        .count      (count2),
        .overflow   (overflow2)
    );

    // Every accepted report is checked against the front of the scoreboard.
    always @(negedge clk) begin
        if (rpt_valid && rpt_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got rule=%0d ofs=%0d, required no entry",
                         rpt_rule, rpt_offset);
            end else begin
                exp_e = sb.pop_front();
                if ({rpt_rule, rpt_offset} !== exp_e) begin
                    bad++;
                    $display("FAIL pop_order: got rule=%0d ofs=%0d, required rule=%0d ofs=%0d",
                             rpt_rule, rpt_offset, exp_e[36:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        match = '0;
        rpt_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        ofs_model = '0;
        sb.delete();
    endtask

    task automatic drive_char(input logic [31:0] m, input bit accept);
        en = 1'b1;
        match = m;
        if (accept) begin
            for (int b = 0; b < 32; b++) begin
                if (m[b]) sb.push_back({5'(b), ofs_model});
            end
        end
        step();
        ofs_model = ofs_model + 32'd1;
        en = 1'b0;
        match = '0;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && count == 0) break;
            step();
        end
        total++;
        if (!(sb.size() == 0 && count == 0)) begin
            bad++;
            $display("FAIL %s_drain: got pending=%0d count=%0d, required 0 and 0",
                     name, sb.size(), count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total += 4;
        if (hold !== 1'b0) begin bad++; $display("FAIL reset_hold: got %b, required 0", hold); end
        if (rpt_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b, required 0", rpt_valid);
        end
        if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d, required 0", count); end
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL reset_overflow: got %b, required 0", overflow);
        end
    endtask

    task automatic test_single();
        int hold_cycles = 0;
        do_reset();
        rpt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_char((i == 3) ? 32'h4 : 32'h0, i == 3);
            if (hold) hold_cycles++;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (hold) hold_cycles++;
        end
        total += 2;
        if (hold_cycles != 1) begin
            bad++; $display("FAIL single_hold: got %0d cycles, required 1", hold_cycles);
        end
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL single_overflow: got %b, required 0", overflow);
        end
        wait_empty("single");
    endtask

    task automatic test_multi();
        int hold_cycles = 0;
        do_reset();
        drive_char(32'h8000_0011, 1'b1);
        if (hold) hold_cycles++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (hold) hold_cycles++;
        end
        total += 2;
        if (hold_cycles != 3) begin
            bad++; $display("FAIL multi_hold: got %0d cycles, required 3", hold_cycles);
        end
        if (count !== 5'd3) begin bad++; $display("FAIL multi_count: got %0d, required 3", count); end
        rpt_ready = 1'b1;
        wait_empty("multi");
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_char(32'(1) << i, 1'b1);
            step();
        end
        total += 2;
        if (count !== 5'd16) begin bad++; $display("FAIL full_count: got %0d, required 16", count); end
        if (hold !== 1'b1) begin bad++; $display("FAIL full_hold: got %b, required 1", hold); end
        drive_char(32'h2, 1'b0);
        total++;
        if (overflow !== 1'b1) begin
            bad++; $display("FAIL full_overflow: got %b, required 1", overflow);
        end
        rpt_ready = 1'b1;
        step();
        rpt_ready = 1'b0;
        total += 2;
        if (count !== 5'd15) begin
            bad++; $display("FAIL full_pop_count: got %0d, required 15", count);
        end
        if (hold !== 1'b0) begin bad++; $display("FAIL full_pop_hold: got %b, required 0", hold); end
        // Offset of this report proves the dropped character still advanced the counter.
        drive_char(32'h4, 1'b1);
        rpt_ready = 1'b1;
        wait_empty("full");
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive_char(32'(1) << i, 1'b1);
            step();
        end
        drive_char(32'h0000_F000, 1'b1);
        step();
        step();
        step();
        total += 2;
        if (count !== 5'd16) begin bad++; $display("FAIL pp_count: got %0d, required 16", count); end
        if (hold !== 1'b1) begin bad++; $display("FAIL pp_hold: got %b, required 1", hold); end
        rpt_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (count !== 5'd16) begin
                bad++; $display("FAIL pp_steady_%0d: got count=%0d, required 16", i, count);
            end
        end
        step();
        total++;
        if (count !== 5'd15) begin bad++; $display("FAIL pp_after: got %0d, required 15", count); end
        wait_empty("pp");
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        drive_char(32'hF, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ofs_model = '0;
        total += 4;
        if (count !== 5'd0) begin bad++; $display("FAIL rmid_count: got %0d, required 0", count); end
        if (hold !== 1'b0) begin bad++; $display("FAIL rmid_hold: got %b, required 0", hold); end
        if (rpt_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_valid: got %b, required 0", rpt_valid);
        end
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL rmid_overflow: got %b, required 0", overflow);
        end
    endtask

    task automatic test_dedup();
        int reports = 0;
        do_reset();
        rpt_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
`ifdef MATCH_REPORT_DEDUP_EN
            drive_char(32'h1, k == 0);
`else
            drive_char(32'h1, 1'b1);
`endif
            step();
            if (rpt_valid) reports++;
        end
        step();
        total += 2;
`ifdef MATCH_REPORT_DEDUP_EN
        if (reports != 1) begin bad++; $display("FAIL dedup_reports: got %0d, required 1", reports); end
`else
        if (reports != 3) begin bad++; $display("FAIL dedup_reports: got %0d, required 3", reports); end
`endif
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL dedup_overflow: got %b, required 0", overflow);
        end
        wait_empty("dedup");
    endtask

    task automatic test_offset_wrap();
        bit seen = 1'b0;
        for (int i = 0; i < 17; i++) begin
            en2 = 1'b1;
            match2 = (i == 16) ? 32'h1 : 32'h0;
            step();
        end
        en2 = 1'b0;
        match2 = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rpt_valid2) begin
                seen = 1'b1;
                break;
            end
        end
        total += 2;
        if (!seen) begin
            bad++; $display("FAIL wrap_valid: got no report, required one");
        end else if ({rpt_rule2, rpt_offset2} !== 9'd0) begin
            bad++;
            $display("FAIL wrap_report: got rule=%0d ofs=%0d, required rule=0 ofs=0",
                     rpt_rule2, rpt_offset2);
        end
        if (overflow2 !== 1'b0) begin
            bad++; $display("FAIL wrap_overflow: got %b, required 0", overflow2);
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        match = '0;
        rpt_ready = 1'b0;
        en2 = 1'b0;
        match2 = '0;
        ofs_model = '0;
        test_reset();
        test_offset_wrap();
        test_single();
        test_multi();
        test_full();
        test_push_pop_full();
        test_reset_mid_drain();
        test_dedup();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
